// File: rtl/jtag_vpi_shifter.sv
// JTAG bit-bang master: shifts up to MAX_LEN tms/tdi bits per command on a
// divided tck and returns the tdo bits captured on each rising tck edge.
module jtag_vpi_shifter #(
  parameter int unsigned TCK_DIV = 2,
  parameter int unsigned MAX_LEN = 32
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               enable,
  input  logic               init_done,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_tms,
  input  logic [MAX_LEN-1:0] cmd_tdi,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_tdo,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo
);

  localparam int unsigned DW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t             state;
  logic [DW-1:0]      div_cnt;
  logic [5:0]         bits_left;
  logic [5:0]         eff_len;
  logic [MAX_LEN-1:0] tms_sh;
  logic [MAX_LEN-1:0] tdi_sh;
  logic [MAX_LEN-1:0] cap;
  logic [MAX_LEN-1:0] mask;
  logic               accept;
  logic               div_last;

  assign eff_len   = (cmd_len > 6'(MAX_LEN)) ? 6'(MAX_LEN) : cmd_len;
  assign cmd_ready = wb_rst_ni & (state == IDLE) & enable & init_done;
  assign accept    = cmd_valid & cmd_ready;
  assign div_last  = (div_cnt == DW'(TCK_DIV - 1));

  // DONE is a one-cycle response state so cmd_ready stays low alongside rsp_valid.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_tdo   <= '0;
      div_cnt   <= '0;
      bits_left <= '0;
      tms_sh    <= '0;
      tdi_sh    <= '0;
      cap       <= '0;
      mask      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cap       <= '0;
            mask      <= {{(MAX_LEN-1){1'b0}}, 1'b1};
            div_cnt   <= '0;
            bits_left <= eff_len;
            if (eff_len == 6'd0) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_tdo   <= '0;
            end else begin
              state  <= LOW;
              tck    <= 1'b0;
              tms    <= cmd_tms[0];
              tdi    <= cmd_tdi[0];
              tms_sh <= cmd_tms >> 1;
              tdi_sh <= cmd_tdi >> 1;
            end
          end
        end
        LOW: begin
          if (div_last) begin
            state   <= HIGH;
            tck     <= 1'b1;
            div_cnt <= '0;
            if (tdo) cap <= cap | mask;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HIGH: begin
          if (div_last) begin
            tck     <= 1'b0;
            div_cnt <= '0;
            if (bits_left == 6'd1) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_tdo   <= cap;
            end else begin
              state     <= LOW;
              bits_left <= bits_left - 1'b1;
              mask      <= mask << 1;
              tms       <= tms_sh[0];
              tdi       <= tdi_sh[0];
              tms_sh    <= tms_sh >> 1;
              tdi_sh    <= tdi_sh >> 1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_vpi_shifter.sv
// Randomised bench for jtag_vpi_shifter: a waveform model derived from the
// accept time is compared every cycle, plus literal checks of key scenarios.
module tb_jtag_vpi_shifter;

  localparam int unsigned TCK_DIV = 2;
  localparam int unsigned MAX_LEN = 32;
  localparam int          HP      = int'(TCK_DIV);

  logic               clk;
  logic               rst_n;
  logic               enable;
  logic               init_done;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [5:0]         cmd_len;
  logic [MAX_LEN-1:0] cmd_tms;
  logic [MAX_LEN-1:0] cmd_tdi;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_tdo;
  logic               tck;
  logic               tms;
  logic               tdi;
  logic               tdo;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;
  int tdo_mode    = 0;  // 0 random, 1 constant one, 2 loop tdi back
  bit noise       = 1'b0;
  logic tck_prev  = 1'b0;

  jtag_vpi_shifter #(.TCK_DIV(TCK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .enable(enable), .init_done(init_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_tms(cmd_tms), .cmd_tdi(cmd_tdi), .rsp_valid(rsp_valid),
    .rsp_tdo(rsp_tdo), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a command accepted at edge 0 is a sequence of bits, each
  // TCK_DIV cycles low then TCK_DIV high; response lands at edge 2*D*len.
  bit          m_busy = 1'b0;
  bit          m_acc;
  int          m_n, m_len, m_b, m_ph;
  logic [31:0] m_tmsv, m_tdiv, m_cap;
  logic        m_tck = 1'b0, m_tms = 1'b1, m_tdi = 1'b0, m_rv = 1'b0;
  logic [31:0] m_rsp = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_tck = 1'b0; m_tms = 1'b1; m_tdi = 1'b0;
      m_rv = 1'b0; m_rsp = '0;
    end else if (m_busy) begin
      m_n++;
      if (m_n == 2 * HP * m_len) begin
        m_tck = 1'b0; m_rv = 1'b1; m_rsp = m_cap; m_busy = 1'b0;
      end else begin
        m_b   = m_n / (2 * HP);
        m_ph  = m_n % (2 * HP);
        m_tck = (m_ph >= HP);
        m_tms = m_tmsv[m_b];
        m_tdi = m_tdiv[m_b];
        if (m_ph == HP) m_cap[m_b] = tdo;
      end
    end else begin
      m_acc = cmd_valid && !m_rv && enable && init_done;
      m_rv  = 1'b0;
      if (m_acc) begin
        m_len  = (int'(cmd_len) > int'(MAX_LEN)) ? int'(MAX_LEN) : int'(cmd_len);
        m_tmsv = cmd_tms;
        m_tdiv = cmd_tdi;
        m_cap  = '0;
        m_n    = 0;
        if (m_len == 0) begin
          m_rv = 1'b1; m_rsp = '0;
        end else begin
          m_busy = 1'b1; m_tck = 1'b0; m_tms = m_tmsv[0]; m_tdi = m_tdiv[0];
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("tck", tck, m_tck);
    chk("tms", tms, m_tms);
    chk("tdi", tdi, m_tdi);
    chk("rsp_valid", rsp_valid, m_rv);
    chk("rsp_tdo", rsp_tdo, m_rsp);
    chk("cmd_ready", cmd_ready, rst_n && !m_busy && !m_rv && enable && init_done);
    if (tck === 1'b1 && tck_prev === 1'b0) pulses++;
    tck_prev = tck;
  end

  initial begin
    tdo = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      case (tdo_mode)
        1:       tdo = 1'b1;
        2:       tdo = tdi;
        default: tdo = 1'($urandom);
      endcase
    end
  end

  task automatic wait_ready();
    int i;
    for (i = 0; i < 200 && cmd_ready !== 1'b1; i++) @(negedge clk);
    if (cmd_ready !== 1'b1) chk("ready_timeout", cmd_ready, 1);
  endtask

  // Returns just after the accept edge.
  task automatic issue(input logic [5:0] len, input logic [31:0] tv, input logic [31:0] dv);
    wait_ready();
    #1;
    cmd_len = len; cmd_tms = tv; cmd_tdi = dv; cmd_valid = 1'b1;
    pulses = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // lat = number of negedges after the accept edge until rsp_valid is seen.
  task automatic wait_rsp(input int start, output int lat);
    lat = start;
    do begin
      @(negedge clk);
      lat++;
      if (rsp_valid !== 1'b1) begin
        #1;
        if (noise) begin
          cmd_valid = 1'($urandom); cmd_len = 6'($urandom);
          cmd_tms = $urandom; cmd_tdi = $urandom;
        end
      end
    end while (rsp_valid !== 1'b1 && lat < 5000);
    if (rsp_valid !== 1'b1) chk("rsp_timeout", rsp_valid, 1);
    #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    int lat, l, el;
    rst_n = 1'b0; enable = 1'b1; init_done = 1'b1; cmd_valid = 1'b0;
    cmd_len = '0; cmd_tms = '0; cmd_tdi = '0;

    repeat (4) @(negedge clk);
    chk("rst_tck", tck, 0);
    chk("rst_tms", tms, 1);
    chk("rst_tdi", tdi, 0);
    chk("rst_tdo", rsp_tdo, 0);
    chk("rst_ready", cmd_ready, 0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);

    tdo_mode = 1;
    issue(6'd5, 32'h1F, 32'h0);
    wait_rsp(0, lat);
    chk("lat_len5", lat, 21);
    chk("tdo_len5", rsp_tdo, 32'h0000001F);
    chk("pulses_len5", pulses, 5);

    tdo_mode = 2;
    issue(6'd8, 32'h80, 32'hA5);
    wait_rsp(0, lat);
    chk("lat_len8", lat, 33);
    chk("tdo_loop", rsp_tdo, 32'h000000A5);
    chk("pulses_len8", pulses, 8);

    tdo_mode = 0;
    issue(6'd40, $urandom, $urandom);
    wait_rsp(0, lat);
    chk("lat_len40", lat, 129);
    chk("pulses_len40", pulses, 32);

    issue(6'd0, $urandom, $urandom);
    wait_rsp(0, lat);
    chk("lat_len0", lat, 1);
    chk("tdo_len0", rsp_tdo, 0);
    chk("pulses_len0", pulses, 0);

    @(negedge clk);
    #1 init_done = 1'b0; cmd_valid = 1'b1; pulses = 0;
    repeat (10) @(negedge clk);
    chk("ready_no_init", cmd_ready, 0);
    #1 cmd_valid = 1'b0; init_done = 1'b1; enable = 1'b0;
    @(negedge clk);
    #1 cmd_valid = 1'b1;
    repeat (10) @(negedge clk);
    chk("ready_no_en", cmd_ready, 0);
    chk("pulses_gated", pulses, 0);
    #1 cmd_valid = 1'b0; enable = 1'b1;

    issue(6'd8, $urandom, $urandom);
    repeat (3 * 2 * HP + 2) @(negedge clk);
    #1 enable = 1'b0;
    wait_rsp(3 * 2 * HP + 2, lat);
    chk("lat_en_drop", lat, 33);
    chk("pulses_en_drop", pulses, 8);
    repeat (5) @(negedge clk);
    chk("ready_en_low", cmd_ready, 0);
    #1 enable = 1'b1;

    issue(6'd16, 32'hFFFF0000, $urandom);
    repeat (4 * 2 * HP + 2) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_tck", tck, 0);
    chk("abort_tms", tms, 1);
    chk("abort_rv", rsp_valid, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", cmd_ready, 1);
    tdo_mode = 1;
    issue(6'd2, 32'h1, 32'h2);
    wait_rsp(0, lat);
    chk("lat_len2", lat, 9);
    chk("tdo_len2", rsp_tdo, 32'h00000003);

    tdo_mode = 0;
    noise = 1'b1;
    for (int k = 0; k < 25; k++) begin
      l = int'($urandom_range(0, 40));
      el = (l > int'(MAX_LEN)) ? int'(MAX_LEN) : l;
      issue(6'(l), $urandom, $urandom);
      wait_rsp(0, lat);
      chk("lat_rand", lat, 2 * HP * el + 1);
      chk("pulses_rand", pulses, el);
    end
    noise = 1'b0;

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jtag_vpi_shifter.md
Name: jtag_vpi_shifter

Overview:
- Synthesizable JTAG bit-bang master; a host posts shift commands and the block drives tck/tms/tdi pins and returns captured tdo bits.
- Sits between the debug command source and the CPU TAP pins (tms_pad_i/tck_pad_i/tdi_pad_i/tdo_pad_o of the processing unit).
- Only active once enabled and once the system reset has completed (init_done).

Parameters:
- TCK_DIV, 2, clock cycles per tck half-period; legal range 1..255.
- MAX_LEN, 32, width of the tms/tdi/tdo vectors and maximum bits per command.

Ports:
- wb_clk_i  in  1  system clock; all logic on its rising edge.
- wb_rst_ni  in  1  reset, synchronous, active-low.
- enable  in  1  block may accept commands while high.
- init_done  in  1  system reset released; commands accepted only while high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_len  in  6  number of bits to shift; 0..63, values >MAX_LEN clamp to MAX_LEN.
- cmd_tms  in  MAX_LEN  TMS value per bit, LSB first.
- cmd_tdi  in  MAX_LEN  TDI value per bit, LSB first.
- rsp_valid  out  1  one-cycle pulse when a command has completed.
- rsp_tdo  out  MAX_LEN  captured TDO bits, LSB = first bit; unused upper bits 0; held until next response.
- tck  out  1  JTAG clock.
- tms  out  1  JTAG mode select.
- tdi  out  1  JTAG data in.
- tdo  in  1  JTAG data out from TAP.

Behaviour:
- Reset (wb_rst_ni=0 at a clock edge): tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_tdo=0, state IDLE.
- Reset mid-shift aborts the command immediately; no response is produced.
- cmd_ready = (state==IDLE) & enable & init_done. Accept = cmd_valid & cmd_ready; vectors and length are latched on accept.
- States:
  - IDLE: waits for accept.
  - LOW: tck=0, tms/tdi driven with the current bit; lasts TCK_DIV cycles.
  - HIGH: tck=1; lasts TCK_DIV cycles.
  - After HIGH: go to LOW for the next bit, or finish if the last bit is done.
- On the cycle after accept: tck=0 and tms/tdi = bit 0.
- tdo is sampled into rsp_tdo[bit] at the clock edge that drives tck 0->1.
- After the last HIGH phase: tck returns to 0, rsp_valid=1 for that one cycle, state returns to IDLE.
- Latency: rsp_valid asserts exactly 2*TCK_DIV*len+1 cycles after the accept edge.
- cmd_ready rises again on the cycle after rsp_valid.
- tms/tdi hold the last shifted bit values while idle.
- len=0: no tck activity; rsp_valid on the cycle after accept with rsp_tdo=0.
- enable or init_done dropping mid-command: the current command completes normally; no new command is accepted until both are high.
- cmd_valid while busy is ignored (no buffering).
- tck is a registered output; it never glitches and never pulses outside LOW/HIGH.

Test Plan:
- Reset held low, then released with enable=1, init_done=1 -> tck=0, tms=1, tdi=0, rsp_tdo=0; cmd_ready=1 on the first cycle after release.
- TCK_DIV=2, len=5, tms=5'b11111, tdi=0, tdo tied 1 -> exactly 5 tck pulses, each 2 cycles high and 2 low; rsp_valid 21 cycles after accept; rsp_tdo=32'h0000001F.
- TCK_DIV=2, len=8, tdi=8'hA5, tms=8'h80, TAP model loops tdi to tdo with a half-period delay -> tdi bits seen LSB first as 1,0,1,0,0,1,0,1; rsp_tdo=32'h000000A5; tms=1 only during bit 7.
- len=40 -> clamped to 32 bits, 32 tck pulses; len=0 -> no tck, rsp_valid one cycle after accept, rsp_tdo=0.
- init_done=0 or enable=0 with cmd_valid=1 -> cmd_ready=0, no tck activity. Dropping enable at bit 3 of a len=8 command -> all 8 bits complete, then cmd_ready stays 0.
- Reset asserted during bit 4 of a len=16 command -> next edge: tck=0, tms=1, no rsp_valid; a fresh len=2 command after release completes normally.
